// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue: exception codes used across the
// pipeline and the layout of one queued fetch entry.
package fetch_queue_pkg;

    // Pipeline-wide exception codes; 0 means the fetch completed cleanly.
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    // One queued fetch: 32-bit PC, 32-bit instruction, 5-bit exception code (69 bits).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } fq_entry_t;

    // Build the stored entry. An address-error fetch never returned a real
    // instruction, so its word is replaced with 0 (a nop) before storage.
    function automatic fq_entry_t make_entry(input logic [31:0] pc,
                                             input logic [31:0] instr,
                                             input logic [4:0]  exc,
                                             input logic [4:0]  adel_code);
        fq_entry_t e;
        e.pc    = pc;
        e.instr = (exc == adel_code) ? 32'd0 : instr;
        e.exc   = exc;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode. First-word fall-through
// FIFO with flush, a hold that stops fetching past a faulting entry, and
// zeroed outputs (nop bubble) whenever the queue is empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [4:0] EXC_ADEL = fetch_queue_pkg::EXC_ADEL
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [31:0]              enq_pc,
    input  logic [31:0]              enq_instr,
    input  logic [4:0]               enq_exc,
    output logic                     enq_ready,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [31:0]              deq_pc,
    output logic [31:0]              deq_instr,
    output logic [4:0]               deq_exc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fq_entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 exc_hold_q, exc_hold_d;

    logic                 do_enq;
    logic                 do_deq;
    fq_entry_t            head_entry;

    // Handshakes: accept only when there is room, no fault is pending and no flush.
    assign enq_ready = (count_q != CNT_W'(DEPTH)) && !exc_hold_q && !flush;
    assign deq_valid = (count_q != '0);
    assign do_enq    = enq_valid && enq_ready;
    assign do_deq    = deq_valid && deq_ready;
    assign count     = count_q;

    // Head presentation: stale storage is masked to zero when the queue is empty.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        deq_pc     = '0;
        deq_instr  = '0;
        deq_exc    = '0;
        head_entry = mem_q[head_q];
        if (deq_valid) begin
            deq_pc    = head_entry.pc;
            deq_instr = head_entry.instr;
            deq_exc   = head_entry.exc;
        end
    end

    // Next-state for pointers, occupancy and the fault hold.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        exc_hold_d = exc_hold_q;
        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            exc_hold_d = 1'b0;
        end else begin
            if (do_enq) begin
                tail_d = tail_q + PTR_W'(1);
                if (enq_exc != EXC_NONE) begin
                    exc_hold_d = 1'b1;
                end
            end
            if (do_deq) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register; synchronous reset wins over flush and traffic.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            exc_hold_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            exc_hold_q <= exc_hold_d;
        end
    end

    // Entry storage: written at the tail on an accepted enqueue.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count gating and output masking keep stale entries invisible.
        if (do_enq) begin
            mem_q[tail_q] <= make_entry(enq_pc, enq_instr, enq_exc, EXC_ADEL);
        end
    end

endmodule
